// File: rtl/ex_mul_unit_pkg.sv
// Shared types and constants for the EX-stage iterative multiplier.
// The ALU opcode macros mirror the shared defines.v opcode table.
`ifndef ALU_MUL
`define ALU_ADD    4'h0
`define ALU_SUB    4'h1
`define ALU_AND    4'h2
`define ALU_OR     4'h3
`define ALU_XOR    4'h4
`define ALU_SLL    4'h5
`define ALU_SRL    4'h6
`define ALU_SRA    4'h7
`define ALU_SLT    4'h8
`define ALU_SLTU   4'h9
`define ALU_MUL    4'hA
`define ALU_MULH   4'hB
`define ALU_MULHSU 4'hC
`define ALU_MULHU  4'hD
`endif

package ex_mul_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_t;

    localparam int         MUL_ITERS = 32;
    localparam logic [4:0] LAST_ITER = 5'(MUL_ITERS - 1);

    function automatic logic is_mul_op(
        input logic [3:0] op
    );
        logic r;
        r = 1'b0;
        unique case (1'b1)
            (op == `ALU_MUL):    r = 1'b1;
            (op == `ALU_MULH):   r = 1'b1;
            (op == `ALU_MULHSU): r = 1'b1;
            (op == `ALU_MULHU):  r = 1'b1;
            default:             r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Applies the stored result sign to the magnitude product
// and selects the low or high result word.
module mul_sign_fix #(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] prod,
    input  logic              sign,
    input  logic              sel_hi,
    output logic [XLEN-1:0]   word
);

    logic [2*XLEN-1:0] fixed;

    assign fixed = sign ? ({(2*XLEN){1'b0}} - prod) : prod;
    assign word  = sel_hi ? fixed[2*XLEN-1:XLEN]
                          : fixed[XLEN-1:0];

endmodule

// File: rtl/ex_mul_unit.sv
// Iterative radix-2 shift-add multiplier for the RV32M
// MUL/MULH/MULHSU/MULHU group, stalling EX while it runs.
module ex_mul_unit
    import ex_mul_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_start,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            mul_busy,
    output logic            mul_stall,
    output logic            mul_done,
    output logic [XLEN-1:0] mul_result
);

    mul_state_t state;
    mul_state_t state_nx;

    logic [4:0]        cnt;
    logic              fin;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mcand;
    logic [3:0]        op_q;
    logic              sign_q;

    logic              accept;
    logic              signed_a;
    logic              signed_b;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN:0]     sum;
    logic [2*XLEN-1:0] step;
    logic              sel_hi;
    logic [XLEN-1:0]   fix_word;

    assign accept = (state == IDLE) && mul_start
                  && is_mul_op(alu_op) && !flush;

    assign signed_a = (alu_op != `ALU_MULHU);
    assign signed_b = (alu_op == `ALU_MUL)
                   || (alu_op == `ALU_MULH);

    assign neg_a = signed_a && op_a[XLEN-1];
    assign neg_b = signed_b && op_b[XLEN-1];
    assign mag_a = neg_a ? -op_a : op_a;
    assign mag_b = neg_b ? -op_b : op_b;

    // Multiplier sits in the low half and shifts out as the
    // partial sum grows into the high half.
    assign sum  = {1'b0, acc[2*XLEN-1:XLEN]}
                + (acc[0] ? {1'b0, mcand} : '0);
    assign step = {sum, acc[XLEN-1:1]};

    assign sel_hi = (op_q != `ALU_MUL);

    mul_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .prod   (acc),
        .sign   (sign_q),
        .sel_hi (sel_hi),
        .word   (fix_word)
    );

    assign mul_busy  = (state == CALC);
    assign mul_done  = (state == DONE);
    assign mul_stall = accept || (state == CALC);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = CALC;
            end
            CALC: begin
                if (flush)    state_nx = IDLE;
                else if (fin) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            fin        <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            op_q       <= '0;
            sign_q     <= 1'b0;
            mul_result <= '0;
        end else if (accept) begin
            cnt    <= '0;
            fin    <= 1'b0;
            acc    <= {{XLEN{1'b0}}, mag_b};
            mcand  <= mag_a;
            op_q   <= alu_op;
            sign_q <= neg_a ^ neg_b;
        end else if ((state == CALC) && !flush) begin
            // fin marks the extra cycle that publishes the result
            if (!fin) begin
                acc <= step;
                cnt <= cnt + 5'd1;
                if (cnt == LAST_ITER) fin <= 1'b1;
            end else begin
                mul_result <= fix_word;
            end
        end
    end

endmodule

// File: tb/tb_ex_mul_unit.sv
// Directed self-checking bench for ex_mul_unit: vector table
// plus flush, reset, busy-restart and non-multiply sequences.
`ifndef ALU_MUL
`define ALU_ADD    4'h0
`define ALU_MUL    4'hA
`define ALU_MULH   4'hB
`define ALU_MULHSU 4'hC
`define ALU_MULHU  4'hD
`endif

module tb_ex_mul_unit;

    logic        clk;
    logic        rst_n;
    logic        mul_start;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        mul_busy;
    logic        mul_stall;
    logic        mul_done;
    logic [31:0] mul_result;

    int n_pass;
    int n_total;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[13];

    ex_mul_unit #(
        .XLEN (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mul_start  (mul_start),
        .alu_op     (alu_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .mul_busy   (mul_busy),
        .mul_stall  (mul_stall),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h",
                     nm, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input string nm);
        @(negedge clk);
        mul_start = 1'b1;
        alu_op    = op;
        op_a      = a;
        op_b      = b;
        #1;
        chk({nm, " stall_req"}, {31'b0, mul_stall}, 32'd1);
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        chk({nm, " busy"}, {31'b0, mul_busy}, 32'd1);
    endtask

    task automatic wait_done(input string nm,
                             input logic [31:0] exp);
        int n;
        n = 0;
        while (!mul_done && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'd33);
        chk({nm, " result"}, mul_result, exp);
        @(posedge clk);
        #1;
        chk({nm, " pulse"}, {31'b0, mul_done}, 32'd0);
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        rst_n     = 1'b0;
        mul_start = 1'b0;
        alu_op    = `ALU_ADD;
        op_a      = '0;
        op_b      = '0;
        flush     = 1'b0;

        vecs[0]  = '{`ALU_MUL,    32'd7,        32'hFFFFFFFD,
                     32'hFFFFFFEB, "mul_7_m3"};
        vecs[1]  = '{`ALU_MULH,   32'h80000000, 32'h80000000,
                     32'h40000000, "mulh_min_min"};
        vecs[2]  = '{`ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFE, "mulhu_max"};
        vecs[3]  = '{`ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'hFFFFFFFF, "mulhsu_m1"};
        vecs[4]  = '{`ALU_MUL,    32'h0,        32'h12345678,
                     32'h00000000, "mul_zero"};
        vecs[5]  = '{`ALU_MUL,    32'h12345678, 32'h10,
                     32'h23456780, "mul_shift"};
        vecs[6]  = '{`ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'h00000000, "mulh_m1_m1"};
        vecs[7]  = '{`ALU_MULH,   32'h80000000, 32'h1,
                     32'hFFFFFFFF, "mulh_min_1"};
        vecs[8]  = '{`ALU_MULHU,  32'h80000000, 32'h2,
                     32'h00000001, "mulhu_carry"};
        vecs[9]  = '{`ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF,
                     32'h00000001, "mul_m1_m1"};
        vecs[10] = '{`ALU_MULHSU, 32'h80000000, 32'hFFFFFFFF,
                     32'h80000000, "mulhsu_min"};
        vecs[11] = '{`ALU_MULHU,  32'h00010000, 32'h00010000,
                     32'h00000001, "mulhu_2p32"};
        vecs[12] = '{`ALU_MULH,   32'h7FFFFFFF, 32'h7FFFFFFF,
                     32'h3FFFFFFF, "mulh_max_max"};

        #12;
        chk("rst busy",   {31'b0, mul_busy},  32'd0);
        chk("rst done",   {31'b0, mul_done},  32'd0);
        chk("rst stall",  {31'b0, mul_stall}, 32'd0);
        chk("rst result", mul_result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].nm);
            wait_done(vecs[i].nm, vecs[i].exp);
        end

        // Flush at iteration 10, then immediate restart
        issue(`ALU_MUL, 32'd3, 32'd5, "flush_op");
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush busy",   {31'b0, mul_busy}, 32'd0);
        chk("flush done",   {31'b0, mul_done}, 32'd0);
        chk("flush result", mul_result,        32'h3FFFFFFF);
        issue(`ALU_MUL, 32'd3, 32'd5, "after_flush");
        wait_done("after_flush", 32'd15);

        // mul_start held while busy with other operands
        issue(`ALU_MUL, 32'd7, 32'hFFFFFFFD, "busy_restart");
        mul_start = 1'b1;
        alu_op    = `ALU_MUL;
        op_a      = 32'd1;
        op_b      = 32'd1;
        wait_done("busy_restart", 32'hFFFFFFEB);
        mul_start = 1'b0;

        // Non-multiply opcode is ignored
        @(negedge clk);
        mul_start = 1'b1;
        alu_op    = `ALU_ADD;
        op_a      = 32'd9;
        op_b      = 32'd9;
        #1;
        chk("add stall", {31'b0, mul_stall}, 32'd0);
        @(posedge clk);
        #1;
        chk("add busy",   {31'b0, mul_busy}, 32'd0);
        chk("add result", mul_result,        32'hFFFFFFEB);

        // Flush beats start in IDLE
        @(negedge clk);
        alu_op = `ALU_MUL;
        flush  = 1'b1;
        #1;
        chk("flush_start stall", {31'b0, mul_stall}, 32'd0);
        @(posedge clk);
        #1;
        mul_start = 1'b0;
        flush     = 1'b0;
        chk("flush_start busy", {31'b0, mul_busy}, 32'd0);

        // Reset at iteration 20, then accept on first edge
        issue(`ALU_MUL, 32'd6, 32'd7, "rst_op");
        repeat (19) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy",   {31'b0, mul_busy},  32'd0);
        chk("midrst done",   {31'b0, mul_done},  32'd0);
        chk("midrst stall",  {31'b0, mul_stall}, 32'd0);
        chk("midrst result", mul_result,         32'd0);
        rst_n = 1'b1;
        issue(`ALU_MULHU, 32'h00010000, 32'h00030000, "post_rst");
        wait_done("post_rst", 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
